sram_arbiter_ctrl: RTL and testbench

- Shares one external 16-bit asynchronous SRAM (256K x 16, byte lanes) between two requesters.
  - Port 0: video/game logic.
  - Port 1: Nios II bridge.
- Round-robin arbitration; sequences each access through a fixed setup/strobe/done state machine.
- Drives the SRAM pins and the tristate control.
- Holds the last read word on rdata, which feeds the SRAM read-back PIO's 16-bit input port.

---
 rtl/sram_arbiter_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin arbiter and setup/strobe/done sequencer for a 16-bit async SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN to give port 0 absolute priority over port 1.
module sram_arbiter_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [15:0]       req0_wdata,
    input  logic [1:0]        req0_be,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [15:0]       req1_wdata,
    input  logic [1:0]        req1_be,
    output logic              req1_done,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              owner, last_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_wdata;
    logic [1:0]        lat_be;
    logic              grant_any, grant_sel;

    // grant_sel is the winning port number; only meaningful when grant_any is high
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        grant_sel = ~req0_valid;
`else
        if (req0_valid && req1_valid)
            grant_sel = ~last_owner;
        else
            grant_sel = ~req0_valid;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_owner resets to 1 so that port 0 takes the first contended grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 16'h0000;
            lat_be     <= 2'b00;
            rdata      <= 16'h0000;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    owner      <= grant_sel;
                    last_owner <= grant_sel;
                    lat_we     <= grant_sel ? req1_we    : req0_we;
                    lat_addr   <= grant_sel ? req1_addr  : req0_addr;
                    lat_wdata  <= grant_sel ? req1_wdata : req0_wdata;
                    lat_be     <= grant_sel ? req1_be    : req0_be;
                end
                SETUP: cnt <= 4'(WAIT_CYCLES - 1);
                ACCESS: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else if (!lat_we)
                        rdata <= sram_dq_in;
                end
                default: ;
            endcase
        end
    end

    // Writes keep ce_n, lanes and dq driven through DONE so data is held after we_n rises
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        case (state)
            SETUP, ACCESS: begin
                sram_ce_n = 1'b0;
                if (lat_we) begin
                    sram_dq_oe = 1'b1;
                    sram_ub_n  = ~lat_be[1];
                    sram_lb_n  = ~lat_be[0];
                    sram_we_n  = (state != ACCESS);
                end else begin
                    sram_oe_n = 1'b0;
                    sram_ub_n = 1'b0;
                    sram_lb_n = 1'b0;
                end
            end
            DONE: begin
                if (lat_we) begin
                    sram_ce_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_ub_n  = ~lat_be[1];
                    sram_lb_n  = ~lat_be[0];
                end
                req0_done = ~owner;
                req1_done = owner;
            end
            default: ;
        endcase
    end

    assign sram_addr   = lat_addr;
    assign sram_dq_out = lat_wdata;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Self-checking bench for sram_arbiter_ctrl: directed scenarios plus randomized two-port traffic
// checked against a transaction-level memory/rdata model.
module tb_sram_arbiter_ctrl;

    localparam int ADDR_W = 18;
    localparam int W      = 2;
    localparam int OCC    = 3 + W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req0_valid, req0_we, req0_done;
    logic [ADDR_W-1:0] req0_addr;
    logic [15:0]       req0_wdata;
    logic [1:0]        req0_be;
    logic              req1_valid, req1_we, req1_done;
    logic [ADDR_W-1:0] req1_addr;
    logic [15:0]       req1_wdata;
    logic [1:0]        req1_be;
    logic [15:0]       rdata;
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out, sram_dq_in;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [15:0] ref_rdata;
    int checks = 0;
    int errors = 0;

    sram_arbiter_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_done(req1_done),
        .rdata(rdata), .busy(busy), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // Async SRAM read path
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    // Advance one cycle and sample mid-cycle; the SRAM model commits enabled write lanes here
    task automatic step();
        @(posedge clk);
        #1;
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  = sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] = sram_dq_out[15:8];
        end
    endtask

    task automatic ref_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        if (be[0]) ref_mem[a][7:0]  = d[7:0];
        if (be[1]) ref_mem[a][15:8] = d[15:8];
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = 0; req0_be = 0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = 0; req1_be = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        step();
        step();
        reset_n   = 1;
        ref_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        step();
        step();
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
                errors++; $display("[TB] FAIL reset_strobes got %b want 11111",
                    {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
            end
            checks++;
            if ({sram_dq_oe, busy, req0_done, req1_done} !== 4'b0000) begin
                errors++; $display("[TB] FAIL reset_ctrl got %b want 0000",
                    {sram_dq_oe, busy, req0_done, req1_done});
            end
            checks++;
            if (rdata !== 16'h0 || sram_addr !== '0 || sram_dq_out !== 16'h0) begin
                errors++; $display("[TB] FAIL reset_data rdata=%h addr=%h dq=%h want zeros",
                    rdata, sram_addr, sram_dq_out);
            end
            reset_n = 1;
            step();
        end
        ref_rdata = 16'h0000;
    endtask

    task automatic test_single_read();
        int strobe = 0, done_at = -1, ndone = 0, wrong = 0;
        mem[10'h010] = 16'hBEEF; ref_mem[10'h010] = 16'hBEEF;
        req1_valid = 1; req1_we = 0; req1_addr = 18'h00010;
        for (int k = 1; k <= OCC + 2; k++) begin
            step();
            if (!sram_ce_n && !sram_oe_n) strobe++;
            if (req0_done) wrong++;
            if (req1_done) begin ndone++; done_at = k; req1_valid = 0; end
        end
        ref_rdata = 16'hBEEF;
        checks++;
        if (strobe != 1 + W) begin
            errors++; $display("[TB] FAIL read_strobe_len got %0d want %0d", strobe, 1 + W);
        end
        checks++;
        if (done_at != 2 + W || ndone != 1) begin
            errors++; $display("[TB] FAIL read_latency got cycle %0d count %0d want cycle %0d count 1",
                done_at, ndone, 2 + W);
        end
        checks++;
        if (wrong != 0) begin
            errors++; $display("[TB] FAIL read_wrong_done got %0d req0 pulses want 0", wrong);
        end
        checks++;
        if (rdata !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL read_data got %h want BEEF", rdata);
        end
    endtask

    task automatic test_byte_write();
        int we_low = 0, we_bad = 0, oe_cyc = 0, lb_low = 0, ub_low = 0, done_at = -1;
        logic [15:0] expv;
        req0_valid = 1; req0_we = 1; req0_addr = 18'h00020; req0_wdata = 16'h1234; req0_be = 2'b01;
        for (int k = 1; k <= OCC + 2; k++) begin
            step();
            if (!sram_we_n) begin
                we_low++;
                if (sram_ce_n || !sram_oe_n || !sram_dq_oe) we_bad++;
            end
            if (sram_dq_oe) begin
                oe_cyc++;
                if (sram_dq_out !== 16'h1234) we_bad++;
            end
            if (!sram_ce_n && !sram_lb_n) lb_low++;
            if (!sram_ub_n) ub_low++;
            if (req0_done) begin done_at = k; req0_valid = 0; end
        end
        ref_write(10'h020, 16'h1234, 2'b01);
        expv = ref_mem[10'h020];
        checks++;
        if (we_low != W || we_bad != 0) begin
            errors++; $display("[TB] FAIL write_we_pulse got %0d cycles (%0d bad) want %0d", we_low, we_bad, W);
        end
        checks++;
        if (oe_cyc != 2 + W || lb_low != 2 + W || ub_low != 0) begin
            errors++; $display("[TB] FAIL write_lanes got oe=%0d lb=%0d ub=%0d want %0d %0d 0",
                oe_cyc, lb_low, ub_low, 2 + W, 2 + W);
        end
        checks++;
        if (done_at != 2 + W) begin
            errors++; $display("[TB] FAIL write_latency got %0d want %0d", done_at, 2 + W);
        end
        checks++;
        if (mem[10'h020] !== expv || mem[10'h020][7:0] !== 8'h34) begin
            errors++; $display("[TB] FAIL write_mem got %h want %h", mem[10'h020], expv);
        end
        checks++;
        if (rdata !== ref_rdata) begin
            errors++; $display("[TB] FAIL write_keeps_rdata got %h want %h", rdata, ref_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int d[$];
        logic [15:0] wd = 16'($urandom);
        req1_valid = 1; req1_we = 1; req1_addr = 18'h00104; req1_wdata = wd; req1_be = 2'b11;
        for (int k = 1; k <= 2 * OCC + 4; k++) begin
            step();
            if (req1_done) begin
                d.push_back(k);
                if (d.size() == 1) begin
                    req1_we = 0; req1_addr = 18'h00104; req1_wdata = 16'($urandom);
                end else begin
                    req1_valid = 0;
                end
            end
        end
        ref_write(10'h104, wd, 2'b11);
        ref_rdata = ref_mem[10'h104];
        checks++;
        if (d.size() != 2) begin
            errors++; $display("[TB] FAIL b2b_done_count got %0d want 2", d.size());
        end else begin
            checks++;
            if (d[1] - d[0] != OCC) begin
                errors++; $display("[TB] FAIL b2b_spacing got %0d want %0d", d[1] - d[0], OCC);
            end
        end
        checks++;
        if (rdata !== ref_rdata) begin
            errors++; $display("[TB] FAIL b2b_readback got %h want %h", rdata, ref_rdata);
        end
    endtask

    task automatic test_contention();
        int order[$];
        int last_k = 0, k = 0, exp_p;
        do_reset();
        req0_valid = 1; req0_we = 0; req0_addr = 18'h00100;
        req1_valid = 1; req1_we = 0; req1_addr = 18'h00101;
        while (order.size() < 6 && k < 6 * OCC + 10) begin
            step();
            k++;
            if (req0_done && req1_done) begin
                checks++; errors++; $display("[TB] FAIL cont_dual_done got both want one");
            end
            if (req0_done || req1_done) begin
                order.push_back(req1_done ? 1 : 0);
                ref_rdata = ref_mem[req1_done ? 10'h101 : 10'h100];
                checks++;
                if (order.size() > 1 && k - last_k != OCC) begin
                    errors++; $display("[TB] FAIL cont_spacing got %0d want %0d", k - last_k, OCC);
                end
                last_k = k;
            end
        end
        clear_inputs();
        step();
        step();
        checks++;
        if (order.size() != 6) begin
            errors++; $display("[TB] FAIL cont_count got %0d want 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            exp_p = 0;
`else
            exp_p = i % 2;
`endif
            checks++;
            if (order[i] != exp_p) begin
                errors++; $display("[TB] FAIL cont_grant_%0d got port %0d want port %0d", i, order[i], exp_p);
            end
        end
        checks++;
        if (rdata !== ref_rdata) begin
            errors++; $display("[TB] FAIL cont_rdata got %h want %h", rdata, ref_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int stray = 0, first = -1;
        req1_valid = 1; req1_we = 1; req1_addr = 18'h003FF; req1_wdata = 16'hA5A5; req1_be = 2'b11;
        step();
        step();
        reset_n = 0;
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy} !== 7'b1111100) begin
            errors++; $display("[TB] FAIL midrst_async got %b want 1111100",
                {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy});
        end
        clear_inputs();
        for (int k = 0; k < OCC; k++) begin
            step();
            if (req0_done || req1_done) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", stray);
        end
        reset_n = 1;
        ref_rdata = 16'h0000;
        req0_valid = 1; req0_we = 0; req0_addr = 18'h00100;
        req1_valid = 1; req1_we = 0; req1_addr = 18'h00101;
        for (int k = 0; k < OCC + 4 && first < 0; k++) begin
            step();
            if (req0_done) first = 0;
            else if (req1_done) first = 1;
        end
        if (first == 0) ref_rdata = ref_mem[10'h100];
        else if (first == 1) ref_rdata = ref_mem[10'h101];
        clear_inputs();
        step();
        step();
        checks++;
        if (first != 0) begin
            errors++; $display("[TB] FAIL midrst_first_grant got port %0d want port 0", first);
        end
    endtask

    task automatic drive_ports(input logic act[2], input logic twe[2], input logic [9:0] ta[2],
                               input logic [15:0] twd[2], input logic [1:0] tbe[2]);
        req0_valid = act[0]; req0_we = twe[0]; req0_addr = 18'(ta[0]); req0_wdata = twd[0]; req0_be = tbe[0];
        req1_valid = act[1]; req1_we = twe[1]; req1_addr = 18'(ta[1]); req1_wdata = twd[1]; req1_be = tbe[1];
    endtask

    // Each port issues random reads/writes over a small shared address window with random gaps
    task automatic test_random();
        logic act[2], twe[2];
        logic [9:0] ta[2];
        logic [15:0] twd[2];
        logic [1:0] tbe[2];
        int gap[2], waitc[2];
        int ndone = 0, cyc = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; twe[p] = 0; ta[p] = 0; twd[p] = 0; tbe[p] = 0; gap[p] = 0; waitc[p] = 0;
        end
        while (cyc < 1500 && (cyc < 1200 || act[0] || act[1] || busy)) begin
            step();
            cyc++;
            for (int p = 0; p < 2; p++) begin
                logic d;
                d = (p == 1) ? req1_done : req0_done;
                if (d) begin
                    checks++;
                    if (!act[p]) begin
                        errors++; $display("[TB] FAIL rand_unrequested_done port %0d cycle %0d", p, cyc);
                    end else begin
                        if (twe[p]) ref_write(ta[p], twd[p], tbe[p]);
                        else ref_rdata = ref_mem[ta[p]];
                        act[p] = 0;
                        gap[p] = $urandom_range(0, 3);
                        ndone++;
                    end
                end else if (act[p]) begin
                    waitc[p]++;
                    if (waitc[p] == 2 * OCC + 2) begin
                        checks++; errors++;
                        $display("[TB] FAIL rand_timeout port %0d waited %0d cycles", p, waitc[p]);
                    end
                end
            end
            checks++;
            if (rdata !== ref_rdata) begin
                errors++; $display("[TB] FAIL rand_rdata cycle %0d got %h want %h", cyc, rdata, ref_rdata);
            end
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && cyc < 1200) begin
                    if (gap[p] > 0) gap[p]--;
                    else begin
                        act[p] = 1; waitc[p] = 0;
                        twe[p] = 1'($urandom);
                        ta[p]  = 10'h100 + 10'($urandom_range(0, 7));
                        twd[p] = 16'($urandom);
                        tbe[p] = 2'($urandom);
                    end
                end
            end
            drive_ports(act, twe, ta, twd, tbe);
        end
        clear_inputs();
        checks++;
        if (ndone < 100) begin
            errors++; $display("[TB] FAIL rand_throughput got %0d accesses want >= 100", ndone);
        end
        for (int a = 10'h100; a < 10'h108; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++; $display("[TB] FAIL rand_mem addr %h got %h want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        ref_rdata = 16'h0000;
        test_reset();
        test_single_read();
        test_byte_write();
        test_back_to_back();
        test_contention();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
